weight_sched_ctrl: RTL and testbench
====================================

// Module: weight_sched_ctrl
// PURPOSE
//  Sequences weight_buffer through N filter groups per layer: load, wait for PE array, stream, free.
//  Also arbitrates the single 64-bit memory read port between weight_buffer and the ifmap loader.
//  Sits between the top-level layer controller and weight_buffer / PE array.
// PARAMETERS
//  GRP_W       8     width of filter-group count/index
//  TIMEOUT     1024  max cycles in LOAD before sticky load_timeout error
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      reset, synchronous, active-low
//  cur_mode       in   OP_MODE layer mode; sampled on start, held internally for the run
//  start          in   1      1-cycle pulse from layer controller, accepted only in IDLE
//  num_groups     in   GRP_W  filter groups this layer (0 treated as 1); sampled on start
//  abort          in   1      cancel run from any non-IDLE state
//  pe_ready       in   1      PE array can accept a filter
//  wb_mem_req     in   1      weight_buffer memory request
//  wb_ready       in   1      weight_buffer full (ready_to_output)
//  wb_finish      in   1      weight_buffer stream done (finish_output_delay)
//  if_mem_req     in   1      ifmap loader memory request
//  mem_data_valid in   1      read data valid from memory
//  wb_start_load  out  1      to weight_buffer start_load
//  wb_output_filt out  1      to weight_buffer output_filter
//  wb_free        out  1      to weight_buffer free_weight_buffer (1-cycle pulse)
//  wb_mode        out  OP_MODE latched mode to weight_buffer
//  wb_mem_valid   out  1      mem_data_valid gated to weight_buffer
//  if_mem_valid   out  1      mem_data_valid gated to ifmap loader
//  mem_req        out  1      merged request to memory
//  mem_owner      out  1      0=weight_buffer, 1=ifmap
//  group_idx      out  GRP_W  current filter group
//  busy           out  1      high outside IDLE
//  done           out  1      1-cycle pulse at run completion
//  load_timeout   out  1      sticky error; cleared only by reset or next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, wb_mode=MODE1, mem_owner=0, group_idx=0.
//  FSM states IDLE, LOAD, WAIT_PE, STREAM, FREE, DONE; all outputs registered from state.
//  IDLE: on start -> LOAD next cycle; latch mode, num_groups; group_idx=0; clear load_timeout.
//  LOAD: wb_start_load=1; on wb_ready -> WAIT_PE. Cycle counter; hitting TIMEOUT sets load_timeout,
//    no state change.
//  WAIT_PE: wb_start_load held 1 (weight_buffer ready depends on it); on pe_ready -> STREAM.
//  STREAM: wb_start_load=1, wb_output_filt=1 held until wb_finish seen -> FREE.
//  FREE: wb_start_load=0, wb_output_filt=0, wb_free=1 for exactly one cycle.
//    If group_idx==num_groups-1 -> DONE, else group_idx++ -> LOAD.
//  DONE: done=1 one cycle -> IDLE; group_idx retains last value.
//  abort: any of LOAD/WAIT_PE/STREAM -> FREE, then IDLE; done not asserted. abort in FREE/DONE ignored.
//  start while busy: ignored, no effect.
//  Arbiter: owner holds port while its req high (burst lock).
//    When owner req low and other req high: owner flips next cycle; one dead cycle with mem_req=0.
//    Simultaneous first request from both out of idle port: weight_buffer wins.
//    mem_req = req of current owner; valid routed only to owner, other valid forced 0.
//    wb_mem_req is only honoured in LOAD; outside LOAD it is treated as 0.
//  group_idx width rule: compare uses num_groups-1 computed in GRP_W bits, with num_groups=0
//    mapped to 1.
// STRUCTURE
//  Shared package: OP_MODE, new enum wsc_state_t, MEM_OWNER_WB/MEM_OWNER_IF constants.
//  Sub-module mem_port_arb (2-requester burst-lock arbiter with valid demux); FSM in top.
// TESTING
//  Single group: start, num_groups=1, wb_ready @10, pe_ready, wb_finish @20
//    -> one wb_free pulse, done 1 cycle after FREE, group_idx=0.
//  num_groups=3 -> exactly 3 wb_free pulses; group_idx 0,1,2; one done; busy low after.
//  Abort during STREAM -> FREE pulse next cycle, IDLE after, no done, busy falls.
//  Arbiter: both reqs high in LOAD -> owner=0; drop wb_mem_req -> mem_req=0 one cycle, then owner=1;
//    if_mem_valid only.
//  wb_ready never asserted, TIMEOUT=16 -> load_timeout set at cycle 16 and stays set;
//    next start clears it.
//  start pulse while busy and num_groups=0 -> ignored; 0 behaves as 1 group.

Source files
------------

// File: rtl/weight_sched_ctrl_pkg.sv
// Shared types for the weight scheduler slice.
//   OP_MODE       layer operating mode forwarded to weight_buffer
//   wsc_state_t   scheduler FSM state encoding
//   MEM_OWNER_*   read-port owner encoding (0 = weight_buffer, 1 = ifmap loader)
package weight_sched_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } OP_MODE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_PE = 3'd2,
    S_STREAM  = 3'd3,
    S_FREE    = 3'd4,
    S_DONE    = 3'd5
  } wsc_state_t;

  localparam logic MEM_OWNER_WB = 1'b0;
  localparam logic MEM_OWNER_IF = 1'b1;

endpackage

// File: rtl/weight_sched_ctrl_mem_port_arb.sv
// Two-requester burst-lock arbiter for the single memory read port.
//   clk, rst_n      clock, synchronous active-low reset
//   wb_req, if_req  requests from weight_buffer / ifmap loader
//   mem_data_valid  read data valid from memory
//   mem_req         request of the current owner
//   mem_owner       current owner (MEM_OWNER_WB / MEM_OWNER_IF)
//   wb_valid        mem_data_valid routed to weight_buffer
//   if_valid        mem_data_valid routed to ifmap loader
module weight_sched_ctrl_mem_port_arb
  import weight_sched_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic wb_req,
  input  logic if_req,
  input  logic mem_data_valid,
  output logic mem_req,
  output logic mem_owner,
  output logic wb_valid,
  output logic if_valid
);

  logic owner_q;
  logic owner_d;

  // The owner keeps the port while its request is high. Once it drops, the
  // port goes to the other side if it is asking; with no request at all the
  // port parks on weight_buffer so a simultaneous first request favours it.
  // The handover cycle naturally shows mem_req=0 because the owner's req is low.
  always_comb begin
    owner_d = owner_q;
    if (owner_q == MEM_OWNER_WB) begin
      if (!wb_req && if_req) owner_d = MEM_OWNER_IF;
    end else begin
      if (!if_req) owner_d = MEM_OWNER_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) owner_q <= MEM_OWNER_WB;
    else        owner_q <= owner_d;
  end

  assign mem_owner = owner_q;
  assign mem_req   = (owner_q == MEM_OWNER_WB) ? wb_req : if_req;
  assign wb_valid  = mem_data_valid && (owner_q == MEM_OWNER_WB);
  assign if_valid  = mem_data_valid && (owner_q == MEM_OWNER_IF);

endmodule

// File: rtl/weight_sched_ctrl.sv
// Weight scheduler: walks weight_buffer through num_groups filter groups
// (load, wait for PE array, stream, free) and arbitrates the memory read port.
//   clk, rst_n                 clock, synchronous active-low reset
//   cur_mode, num_groups       run configuration, sampled on accepted start
//   start, abort               run control from the layer controller
//   pe_ready                   PE array can take a filter
//   wb_mem_req, wb_ready, wb_finish   weight_buffer status
//   if_mem_req, mem_data_valid memory side
//   wb_start_load, wb_output_filt, wb_free, wb_mode   weight_buffer controls
//   wb_mem_valid, if_mem_valid, mem_req, mem_owner    arbitrated memory port
//   group_idx, busy, done, load_timeout               status
module weight_sched_ctrl
  import weight_sched_ctrl_pkg::*;
#(
  parameter int GRP_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  OP_MODE           cur_mode,
  input  logic             start,
  input  logic [GRP_W-1:0] num_groups,
  input  logic             abort,
  input  logic             pe_ready,
  input  logic             wb_mem_req,
  input  logic             wb_ready,
  input  logic             wb_finish,
  input  logic             if_mem_req,
  input  logic             mem_data_valid,
  output logic             wb_start_load,
  output logic             wb_output_filt,
  output logic             wb_free,
  output OP_MODE           wb_mode,
  output logic             wb_mem_valid,
  output logic             if_mem_valid,
  output logic             mem_req,
  output logic             mem_owner,
  output logic [GRP_W-1:0] group_idx,
  output logic             busy,
  output logic             done,
  output logic             load_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wsc_state_t       state_q, state_d;
  OP_MODE           mode_q;
  logic [GRP_W-1:0] last_idx_q;
  logic [GRP_W-1:0] group_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             aborted_q;
  logic             abortable;
  logic             last_group;

  assign abortable  = (state_q == S_LOAD) || (state_q == S_WAIT_PE) || (state_q == S_STREAM);
  assign last_group = (group_idx_q == last_idx_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD:    if (abort) state_d = S_FREE; else if (wb_ready)  state_d = S_WAIT_PE;
      S_WAIT_PE: if (abort) state_d = S_FREE; else if (pe_ready)  state_d = S_STREAM;
      S_STREAM:  if (abort || wb_finish) state_d = S_FREE;
      S_FREE: begin
        if (aborted_q)       state_d = S_IDLE;
        else if (last_group) state_d = S_DONE;
        else                 state_d = S_LOAD;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Run bookkeeping: configuration latch, group index, abort flag and
  // the LOAD watchdog. The watchdog saturates so the error stays sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= MODE1;
      last_idx_q  <= '0;
      group_idx_q <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        mode_q      <= cur_mode;
        last_idx_q  <= (num_groups == '0) ? '0 : num_groups - GRP_W'(1);
        group_idx_q <= '0;
        timeout_q   <= 1'b0;
        aborted_q   <= 1'b0;
      end
      if (abortable && abort) aborted_q <= 1'b1;
      if (state_q == S_FREE && !aborted_q && !last_group)
        group_idx_q <= group_idx_q + GRP_W'(1);
      if (state_q != S_LOAD) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        timeout_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Moore outputs decoded from the state register; start_load stays high
  // through WAIT_PE/STREAM because weight_buffer's ready depends on it.
  assign wb_start_load  = abortable;
  assign wb_output_filt = (state_q == S_STREAM);
  assign wb_free        = (state_q == S_FREE);
  assign done           = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);
  assign wb_mode        = mode_q;
  assign group_idx      = group_idx_q;
  assign load_timeout   = timeout_q;

  logic wb_req_gated;
  assign wb_req_gated = wb_mem_req && (state_q == S_LOAD);

  weight_sched_ctrl_mem_port_arb u_arb (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_req         (wb_req_gated),
    .if_req         (if_mem_req),
    .mem_data_valid (mem_data_valid),
    .mem_req        (mem_req),
    .mem_owner      (mem_owner),
    .wb_valid       (wb_mem_valid),
    .if_valid       (if_mem_valid)
  );

endmodule

// File: tb/tb_weight_sched_ctrl.sv
module tb_weight_sched_ctrl;
  import weight_sched_ctrl_pkg::*;

  localparam int GRP_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  OP_MODE           cur_mode;
  logic             start, abort, pe_ready, wb_mem_req, wb_ready, wb_finish;
  logic             if_mem_req, mem_data_valid;
  logic [GRP_W-1:0] num_groups;
  logic             wb_start_load, wb_output_filt, wb_free, wb_mem_valid, if_mem_valid;
  logic             mem_req, mem_owner, busy, done, load_timeout;
  OP_MODE           wb_mode;
  logic [GRP_W-1:0] group_idx;

  int checks = 0;
  int errors = 0;
  int free_cnt;

  always #5 clk = ~clk;

  weight_sched_ctrl #(.GRP_W(GRP_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .cur_mode(cur_mode), .start(start),
    .num_groups(num_groups), .abort(abort), .pe_ready(pe_ready),
    .wb_mem_req(wb_mem_req), .wb_ready(wb_ready), .wb_finish(wb_finish),
    .if_mem_req(if_mem_req), .mem_data_valid(mem_data_valid),
    .wb_start_load(wb_start_load), .wb_output_filt(wb_output_filt),
    .wb_free(wb_free), .wb_mode(wb_mode), .wb_mem_valid(wb_mem_valid),
    .if_mem_valid(if_mem_valid), .mem_req(mem_req), .mem_owner(mem_owner),
    .group_idx(group_idx), .busy(busy), .done(done), .load_timeout(load_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with the FSM in LOAD; leaves it in FREE.
  task automatic run_group(input int lc, input int sc);
    repeat (lc) tick();
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    pe_ready = 1'b1; tick(); pe_ready = 1'b0;
    repeat (sc) tick();
    wb_finish = 1'b1; tick(); wb_finish = 1'b0;
  endtask

  task automatic do_start(input OP_MODE m, input logic [GRP_W-1:0] n);
    cur_mode = m; num_groups = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cur_mode = MODE2; start = 1'b0; num_groups = '0; abort = 1'b0;
    pe_ready = 1'b0; wb_mem_req = 1'b0; wb_ready = 1'b0; wb_finish = 1'b0;
    if_mem_req = 1'b0; mem_data_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_start_load", wb_start_load, 0);
    chk("rst_free", wb_free, 0);
    chk("rst_done", done, 0);
    chk("rst_mode", wb_mode, MODE1);
    chk("rst_owner", mem_owner, 0);
    chk("rst_gidx", group_idx, 0);
    chk("rst_timeout", load_timeout, 0);

    // Single group, wb_ready in the 10th LOAD cycle, wb_finish later
    do_start(MODE3, 8'd1);
    chk("t1_load_sl", wb_start_load, 1);
    chk("t1_load_of", wb_output_filt, 0);
    chk("t1_busy", busy, 1);
    chk("t1_mode", wb_mode, MODE3);
    repeat (9) tick();
    chk("t1_still_load", wb_start_load, 1);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    chk("t1_wait_sl", wb_start_load, 1);
    chk("t1_wait_of", wb_output_filt, 0);
    tick();
    chk("t1_wait_hold", wb_output_filt, 0);
    pe_ready = 1'b1; tick(); pe_ready = 1'b0;
    chk("t1_stream_of", wb_output_filt, 1);
    chk("t1_stream_sl", wb_start_load, 1);
    repeat (8) tick();
    wb_finish = 1'b1; tick(); wb_finish = 1'b0;
    chk("t1_free", wb_free, 1);
    chk("t1_free_sl", wb_start_load, 0);
    chk("t1_free_of", wb_output_filt, 0);
    chk("t1_free_done", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_done_free", wb_free, 0);
    chk("t1_gidx", group_idx, 0);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done, 0);

    // Three groups
    free_cnt = 0;
    do_start(MODE2, 8'd3);
    for (int g = 0; g < 3; g++) begin
      chk("t2_gidx", group_idx, g);
      run_group(2 + g, 1 + g);
      if (wb_free) free_cnt++;
      tick();
      chk("t2_free_pulse", wb_free, 0);
      chk("t2_done", done, (g == 2) ? 1 : 0);
    end
    chk("t2_gidx_final", group_idx, 2);
    chk("t2_free_cnt", free_cnt, 3);
    tick();
    chk("t2_busy_after", busy, 0);

    // Abort during STREAM
    do_start(MODE1, 8'd2);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    pe_ready = 1'b1; tick(); pe_ready = 1'b0;
    chk("t3_stream", wb_output_filt, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t3_free", wb_free, 1);
    chk("t3_free_done", done, 0);
    tick();
    chk("t3_idle_busy", busy, 0);
    chk("t3_no_done", done, 0);
    chk("t3_free_gone", wb_free, 0);

    // Arbiter
    do_start(MODE1, 8'd1);
    wb_mem_req = 1'b1; if_mem_req = 1'b1; mem_data_valid = 1'b1; #1;
    chk("t4_owner_wb", mem_owner, 0);
    chk("t4_req", mem_req, 1);
    chk("t4_wb_valid", wb_mem_valid, 1);
    chk("t4_if_valid0", if_mem_valid, 0);
    tick();
    chk("t4_lock", mem_owner, 0);
    wb_mem_req = 1'b0; #1;
    chk("t4_dead_req", mem_req, 0);
    chk("t4_dead_owner", mem_owner, 0);
    tick();
    chk("t4_owner_if", mem_owner, 1);
    chk("t4_req_if", mem_req, 1);
    chk("t4_if_valid", if_mem_valid, 1);
    chk("t4_wb_valid0", wb_mem_valid, 0);
    if_mem_req = 1'b0; mem_data_valid = 1'b0;
    tick();
    chk("t4_park", mem_owner, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    chk("t4_idle", busy, 0);
    wb_mem_req = 1'b1; #1;
    chk("t4_gate_idle", mem_req, 0);
    tick();
    chk("t4_gate_owner", mem_owner, 0);
    wb_mem_req = 1'b0;

    // LOAD timeout
    do_start(MODE4, 8'd1);
    repeat (15) tick();
    chk("t5_before", load_timeout, 0);
    tick();
    chk("t5_set", load_timeout, 1);
    repeat (5) tick();
    chk("t5_sticky", load_timeout, 1);
    chk("t5_still_load", wb_start_load, 1);
    chk("t5_no_wait", wb_output_filt, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    chk("t5_idle_sticky", load_timeout, 1);
    do_start(MODE4, 8'd1);
    chk("t5_cleared", load_timeout, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();

    // num_groups=0 acts as one group; start while busy ignored
    do_start(MODE2, 8'd0);
    num_groups = 8'd5; cur_mode = MODE4; start = 1'b1; tick(); start = 1'b0;
    chk("t6_ign_load", wb_start_load, 1);
    chk("t6_ign_of", wb_output_filt, 0);
    chk("t6_ign_mode", wb_mode, MODE2);
    chk("t6_ign_gidx", group_idx, 0);
    run_group(1, 1);
    chk("t6_free", wb_free, 1);
    tick();
    chk("t6_done", done, 1);
    chk("t6_gidx", group_idx, 0);
    tick();
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
